// File: rtl/crc5_unfold2_checker.sv
// CRC-5 receive checker: re-divides a parallel {data, crc} codeword by G, two bits per
// clock through an unfolded LFSR, and reports the syndrome, a pass flag and a failure count.
module crc5_unfold2_checker #(
    parameter int DATA_W = 6,
    parameter int CRC_W = 5,
    parameter logic [CRC_W-1:0] POLY = 5'b00101,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W+CRC_W-1:0]   codeword_in,
    output logic                      done,
    output logic                      crc_ok,
    output logic [CRC_W-1:0]          syndrome,
    output logic [CNT_W-1:0]          err_cnt
);

    localparam int L = DATA_W + CRC_W;
    localparam int P = L + (L % 2);
    localparam int HALF = P / 2;
    localparam int STEP_BITS = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [P-1:0]           shift_reg;
    logic [P-1:0]           shift_load;
    logic [CRC_W-1:0]       rem;
    logic [CRC_W-1:0]       rem_mid;
    logic [CRC_W-1:0]       rem_next;
    logic [STEP_BITS-1:0]   step_cnt;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r, input logic b);
        logic fb;
        fb = r[CRC_W-1] ^ b;
        return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // Odd-length codewords get a leading zero so the register always drains in pairs.
    always_comb begin
        shift_load = '0;
        shift_load[L-1:0] = codeword_in;
        rem_mid = crc_step(rem, shift_reg[P-1]);
        rem_next = crc_step(rem_mid, shift_reg[P-2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            syndrome  <= '0;
            err_cnt   <= '0;
            shift_reg <= '0;
            rem       <= '0;
            step_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_ready && in_valid) begin
                        shift_reg <= shift_load;
                        rem       <= '0;
                        step_cnt  <= '0;
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    rem       <= rem_next;
                    shift_reg <= {shift_reg[P-3:0], 2'b00};
                    step_cnt  <= step_cnt + 1'b1;
                    if (step_cnt == STEP_BITS'(HALF - 1)) begin
                        syndrome <= rem_next;
                        crc_ok   <= (rem_next == '0);
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // Count saturates so a long burst of bad frames never wraps to a small value.
                    if (!crc_ok && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc5_unfold2_checker.sv
// Self-checking bench for crc5_unfold2_checker: a bit-serial reference model fills a
// scoreboard at acceptance and a monitor compares each done pulse against it.
module tb_crc5_unfold2_checker;

    localparam int DATA_W = 6;
    localparam int CRC_W = 5;
    localparam int CNT_W = 8;
    localparam int L = DATA_W + CRC_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [L-1:0]     codeword_in;
    logic             done;
    logic             crc_ok;
    logic [CRC_W-1:0] syndrome;
    logic [CNT_W-1:0] err_cnt;

    typedef struct {
        logic [CRC_W-1:0] syn;
        logic             ok;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   model_err = 0;
    int   cycle = 0;
    bit   err_pending = 1'b0;

    crc5_unfold2_checker #(
        .DATA_W(DATA_W),
        .CRC_W(CRC_W),
        .POLY(5'b00101),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .codeword_in(codeword_in),
        .done(done),
        .crc_ok(crc_ok),
        .syndrome(syndrome),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    function automatic logic [CRC_W-1:0] ref_syn(input logic [L-1:0] cw);
        logic [CRC_W-1:0] r;
        logic fb;
        r = '0;
        for (int i = L - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ cw[i];
            r = {r[CRC_W-2:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return r;
    endfunction

    function automatic logic [L-1:0] make_good(input logic [DATA_W-1:0] msg);
        logic [L-1:0] tmp;
        tmp = {msg, 5'b00000};
        return {msg, ref_syn(tmp)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: each done is scored against the oldest entry; the following cycle checks
    // that done dropped and that the failure count moved as the model says.
    always @(negedge clk) begin
        exp_t e;
        if (err_pending) begin
            checkOutput("err_cnt", 32'(err_cnt), 32'(model_err));
            checkOutput("done_pulse_width", 32'(done), 32'd0);
            err_pending = 1'b0;
        end else if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("syndrome", 32'(syndrome), 32'(e.syn));
                checkOutput("crc_ok", 32'(crc_ok), 32'(e.ok));
                checkOutput("latency", 32'(cycle - e.acc), 32'd7);
                if (!e.ok && model_err < 255) model_err++;
                err_pending = 1'b1;
            end
        end
    end

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        err_pending = 1'b0;
        model_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_crc_ok", 32'(crc_ok), 32'd0);
        checkOutput("rst_syndrome", 32'(syndrome), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic [L-1:0] cw, input bit hold,
                                 output int waits, output int acc);
        exp_t e;
        waits = 0;
        acc = -1;
        @(negedge clk);
        in_valid = 1'b1;
        codeword_in = cw;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.syn = ref_syn(cw);
        e.ok = (e.syn == '0);
        e.acc = cycle;
        acc = cycle;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    initial begin
        logic [L-1:0] good;
        logic [L-1:0] cw;
        int waits;
        int acc;
        int prev_acc;
        int budget;

        reset = 1'b1;
        in_valid = 1'b0;
        codeword_in = '0;
        resetDut();

        // Scenarios 1-3: clean codeword, LSB flipped, MSB flipped.
        good = 11'b101011_10011;
        applyStimulus(good, 1'b0, waits, acc);
        applyStimulus(11'b101011_10010, 1'b0, waits, acc);
        checkOutput("in_ready_low_cycles", 32'(waits), 32'd7);
        applyStimulus(11'b001011_10011, 1'b0, waits, acc);
        checkOutput("in_ready_low_cycles_2", 32'(waits), 32'd7);

        // Scenario 4: in_valid held high, alternating good/bad codewords.
        prev_acc = -1;
        for (int i = 0; i < 6; i++) begin
            cw = (i % 2 == 0) ? good : (good ^ 11'b00000100000);
            applyStimulus(cw, 1'b1, waits, acc);
            if (prev_acc >= 0) checkOutput("accept_spacing", 32'(acc - prev_acc), 32'd8);
            prev_acc = acc;
        end
        in_valid = 1'b0;

        // Scenario 5: reset three cycles into a run aborts it.
        applyStimulus(good, 1'b0, waits, acc);
        @(negedge clk);
        @(negedge clk);
        resetDut();
        applyStimulus(good, 1'b0, waits, acc);

        // Scenario 6a: saturate the failure counter.
        for (int i = 0; i < 260; i++) begin
            cw = make_good(DATA_W'($urandom)) ^ (11'd1 << $urandom_range(0, L - 1));
            applyStimulus(cw, 1'b0, waits, acc);
        end

        // Scenario 6b: random codewords with zero to two flipped bits.
        for (int i = 0; i < 1000; i++) begin
            cw = make_good(DATA_W'($urandom));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                cw = cw ^ (11'd1 << $urandom_range(0, L - 1));
            end
            applyStimulus(cw, 1'b0, waits, acc);
        end

        budget = 0;
        while ((sb.size() != 0 || err_pending) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("drain_queue", 32'(sb.size()), 32'd0);
        checkOutput("err_cnt_saturated", 32'(err_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
